// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared loader state encoding and stream constants.
package imem_loader_pkg;
    localparam int WORD_W = 32;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: valid/ready byte stream feeding the loader.
interface imem_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: shifts bytes MSB-first into a word; pulses word_valid
// the cycle after the fourth byte.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);
    logic [1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;

    always_comb begin
        cnt_d   = clear ? 2'd0 : byte_valid ? cnt_q + 2'd1 : cnt_q;
        word_d  = (!clear && byte_valid) ? {word_q[WORD_W-9:0], byte_in} : word_q;
        valid_d = !clear && byte_valid && cnt_q == 2'd3;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word       = word_q;
    assign word_valid = valid_q;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream, writes big-endian words into
// instruction memory, verifies an XOR checksum and releases the CPU on success.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 10,
    parameter int         BASE_ADDR  = 0,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    imem_loader_if.slave          s,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [WORD_W-1:0]     imem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error
);
    localparam logic [16:0] MAX_WORDS = 17'((1 << ADDR_WIDTH) - BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [7:0]            csum_q, csum_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  hold_q, hold_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  accept, pk_clear, pk_valid, word_valid;
    logic [15:0]           n_word;
    logic [WORD_W-1:0]     word;

    // The write-strobe cycle is the only cycle the loader refuses a byte.
    assign s.in_ready = !word_valid;
    assign accept     = s.in_valid && s.in_ready;
    assign n_word     = {len_q[15:8], s.in_data};
    assign pk_valid   = accept && state_q == S_DATA;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        csum_d   = csum_q;
        addr_d   = addr_q;
        hold_d   = hold_q;
        done_d   = done_q;
        err_d    = err_q;
        pk_clear = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: if (accept && s.in_data == SYNC_BYTE) begin
                state_d  = S_LEN_HI;
                hold_d   = 1'b1;
                done_d   = 1'b0;
                err_d    = 1'b0;
                csum_d   = '0;
                cnt_d    = '0;
                addr_d   = BASE;
                pk_clear = 1'b1;
            end
            S_LEN_HI: if (accept) begin
                len_d   = {s.in_data, len_q[7:0]};
                state_d = S_LEN_LO;
            end
            S_LEN_LO: if (accept) begin
                len_d   = n_word;
                state_d = n_word == '0 ? S_CSUM : {1'b0, n_word} > MAX_WORDS ? S_ERROR : S_DATA;
                err_d   = n_word != '0 && {1'b0, n_word} > MAX_WORDS;
            end
            S_DATA: begin
                if (accept) csum_d = csum_q ^ s.in_data;
                if (word_valid) begin
                    addr_d  = addr_q + 1'b1;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = cnt_q + 16'd1 == len_q ? S_CSUM : S_DATA;
                end
            end
            S_CSUM: if (accept) begin
                state_d = s.in_data == csum_q ? S_DONE : S_ERROR;
                done_d  = s.in_data == csum_q;
                err_d   = s.in_data != csum_q;
                hold_d  = s.in_data != csum_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
            addr_q  <= BASE;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    imem_loader_byte_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (pk_clear),
        .byte_valid (pk_valid),
        .byte_in    (s.in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    assign imem_we    = word_valid;
    assign imem_wdata = word;
    assign imem_addr  = addr_q;
    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign load_error = err_q;
endmodule
